// File: rtl/sram_axi_arbiter_pkg.sv
// Shared constants and state encodings for the sram-like to AXI arbiter.
// Holds the AXI ID tags, fixed burst fields and both FSM encodings.
package sram_axi_arbiter_pkg;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  localparam logic [7:0] LEN0       = 8'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic {
    AR_IDLE,
    AR_SEND
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } w_state_e;

endpackage

// File: rtl/sram_axi_arbiter_wr.sv
// Single-beat AXI write engine for the data requester.
// AW and W are raised together and retire independently; B completes the access.
module axi_wr_channel
  import sram_axi_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        idle,
  output logic        data_ok,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  w_state_e state, state_next;
  logic     aw_done, w_done;

  // A channel counts as done if it already handshook or handshakes now.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) state <= W_IDLE;
    else       state <= state_next;
  end

  // NOTE: the default at the top covers every path, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      W_IDLE:  if (accept)            state_next = W_SEND;
      W_SEND:  if (aw_done && w_done) state_next = W_RESP;
      W_RESP:  if (bvalid)            state_next = W_IDLE;
      default:                        state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awaddr  <= '0;
      awsize  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
    end else if (state == W_IDLE && accept) begin
      awaddr  <= req_addr;
      awsize  <= {1'b0, req_size};
      awvalid <= 1'b1;
      wdata   <= req_wdata;
      wstrb   <= req_wstrb;
      wvalid  <= 1'b1;
    end else begin
      if (awready) awvalid <= 1'b0;
      if (wready)  wvalid  <= 1'b0;
    end
  end

  assign idle    = (state == W_IDLE);
  assign bready  = (state == W_RESP);
  assign data_ok = bready && bvalid;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI master between the fetch and data sram-like requesters.
// Reads are tracked per ARID; data reads and writes are kept mutually ordered.
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic [7:0]  awlen,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  ar_state_e  ar_state, ar_state_next;
  logic [1:0] rd_pend;   // [0] inst read outstanding, [1] data read outstanding
  logic       data_rd_elig, inst_rd_elig;
  logic       data_rd_accept, inst_rd_accept, wr_accept;
  logic       inst_r_hit, data_r_hit;
  logic       w_idle, wr_data_ok;

  // Data has priority; it waits for any write in flight to finish first.
  assign data_rd_elig   = data_sram_req && !data_sram_wr && !rd_pend[1] && w_idle;
  assign inst_rd_elig   = inst_sram_req && !rd_pend[0];
  assign data_rd_accept = (ar_state == AR_IDLE) && data_rd_elig;
  assign inst_rd_accept = (ar_state == AR_IDLE) && inst_rd_elig && !data_rd_elig;
  assign wr_accept      = w_idle && data_sram_req && data_sram_wr && !rd_pend[1]
                          && !data_rd_accept;

  always_ff @(posedge clk) begin
    if (reset) ar_state <= AR_IDLE;
    else       ar_state <= ar_state_next;
  end

  always_comb begin
    ar_state_next = ar_state;
    case (ar_state)
      AR_IDLE: if (data_rd_accept || inst_rd_accept) ar_state_next = AR_SEND;
      AR_SEND: if (arvalid && arready)               ar_state_next = AR_IDLE;
      default:                                       ar_state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
      arvalid <= 1'b0;
    end else if (data_rd_accept) begin
      arid    <= ID_DATA;
      araddr  <= data_sram_addr;
      arsize  <= {1'b0, data_sram_size};
      arvalid <= 1'b1;
    end else if (inst_rd_accept) begin
      arid    <= ID_INST;
      araddr  <= inst_sram_addr;
      arsize  <= {1'b0, inst_sram_size};
      arvalid <= 1'b1;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // Responses carrying an ID with nothing outstanding are dropped.
  assign inst_r_hit = rvalid && (rid == ID_INST) && rd_pend[0];
  assign data_r_hit = rvalid && (rid == ID_DATA) && rd_pend[1];

  // A set in the same cycle as a clear of the same bit wins.
  always_ff @(posedge clk) begin
    if (reset) rd_pend <= 2'b00;
    else       rd_pend <= (rd_pend & ~{data_r_hit, inst_r_hit})
                          | {data_rd_accept, inst_rd_accept};
  end

  axi_wr_channel u_wr (
    .clk       (clk),
    .reset     (reset),
    .accept    (wr_accept),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wstrb (data_sram_wstrb),
    .req_wdata (data_sram_wdata),
    .idle      (w_idle),
    .data_ok   (wr_data_ok),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  assign inst_sram_addr_ok = inst_rd_accept;
  assign data_sram_addr_ok = data_rd_accept || wr_accept;
  assign inst_sram_data_ok = inst_r_hit;
  assign data_sram_data_ok = data_r_hit || wr_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign rready  = 1'b1;
  assign arlen   = LEN0;
  assign arburst = BURST_INCR;
  assign awid    = ID_DATA;
  assign awlen   = LEN0;
  assign awburst = BURST_INCR;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Self-checking bench for sram_axi_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the arbitration rules.
module tb_sram_axi_arbiter;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  logic        clk, reset;
  logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  arid, rid, awid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  int checks = 0;
  int errors = 0;

  sram_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every read response must correspond to an AR the slave has accepted.
  logic [1:0] ar_seen;
  always @(negedge clk) begin
    if (reset) ar_seen = 2'b00;
    else begin
      if (rvalid) begin
        assert (rid <= 4'd1 && ar_seen[rid[0]])
          else $error("FAIL rid_unexpected: rid=%0d with no read pending", rid);
        if (rid <= 4'd1) ar_seen[rid[0]] = 1'b0;
      end
      if (arvalid && arready && arid <= 4'd1) ar_seen[arid[0]] = 1'b1;
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL rst_aw_w_valid: got %b%b want 00", awvalid, wvalid); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL rst_bready: got %b want 0", bready); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rst_rready: got %b want 1", rready); end
    checks++; if (araddr !== 32'h0 || arid !== 4'h0 || arsize !== 3'h0) begin errors++; $display("FAIL rst_ar_regs: got %h/%h/%h want 0", araddr, arid, arsize); end
    checks++; if (awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0) begin errors++; $display("FAIL rst_w_regs: got %h/%h/%h want 0", awaddr, wdata, wstrb); end
    checks++; if (awid !== ID_DATA || wlast !== 1'b1 || arlen !== 8'd0 || awburst !== 2'b01) begin errors++; $display("FAIL rst_tieoffs: got awid=%h wlast=%b arlen=%h awburst=%b", awid, wlast, arlen, awburst); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_arbitration;
    arready = 1'b1;
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h8000_1000; data_sram_size = 2'd2;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL arb_data_ok_c0: got %b want 1", data_sram_addr_ok); end
    checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL arb_inst_ok_c0: got %b want 0", inst_sram_addr_ok); end
    tick();
    data_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== ID_DATA || araddr !== 32'h8000_1000 || arsize !== 3'd2) begin errors++; $display("FAIL arb_ar_data: got v=%b id=%h a=%h s=%h want 1/1/80001000/2", arvalid, arid, araddr, arsize); end
    checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL arb_inst_ok_c1: got %b want 0", inst_sram_addr_ok); end
    tick();
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL arb_inst_ok_c2: got %b want 1", inst_sram_addr_ok); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL arb_arvalid_c2: got %b want 0", arvalid); end
    tick();
    inst_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== ID_INST || araddr !== 32'hBFC0_0000) begin errors++; $display("FAIL arb_ar_inst: got v=%b id=%h a=%h want 1/0/bfc00000", arvalid, arid, araddr); end
    tick();
    arready = 1'b0;
  endtask

  task automatic test_out_of_order;
    rvalid = 1'b1; rid = ID_INST; rdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h1111_1111) begin errors++; $display("FAIL ooo_inst: got ok=%b d=%h want 1/11111111", inst_sram_data_ok, inst_sram_rdata); end
    checks++; if (data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL ooo_data_quiet: got %b want 0", data_sram_data_ok); end
    tick();
    rid = ID_DATA; rdata = 32'h2222_2222;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h2222_2222) begin errors++; $display("FAIL ooo_data: got ok=%b d=%h want 1/22222222", data_sram_data_ok, data_sram_rdata); end
    checks++; if (inst_sram_data_ok !== 1'b0) begin errors++; $display("FAIL ooo_inst_quiet: got %b want 0", inst_sram_data_ok); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_write_hazard;
    int aw_cycles, w_cycles;
    aw_cycles = 0; w_cycles = 0;
    awready = 1'b0; wready = 1'b1;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_2000;
    data_sram_wdata = 32'hDEAD_BEEF; data_sram_wstrb = 4'b0011; data_sram_size = 2'd2;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b want 1", data_sram_addr_ok); end
    tick();
    data_sram_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) awready = 1'b1;
      @(negedge clk);
      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      if (i == 0) begin
        checks++; if (awaddr !== 32'h8000_2000 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'b0011 || awsize !== 3'd2) begin errors++; $display("FAIL wr_payload: got a=%h d=%h s=%b sz=%h", awaddr, wdata, wstrb, awsize); end
      end
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    checks++; if (aw_cycles != 3) begin errors++; $display("FAIL wr_awvalid_len: got %0d want 3", aw_cycles); end
    checks++; if (w_cycles != 1) begin errors++; $display("FAIL wr_wvalid_len: got %0d want 1", w_cycles); end
    // W_RESP: data read must wait, inst read goes through.
    arready = 1'b1;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h8000_3000;
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0010;
    @(negedge clk);
    checks++; if (bready !== 1'b1 || awvalid !== 1'b0) begin errors++; $display("FAIL wr_resp_state: got bready=%b awvalid=%b want 1/0", bready, awvalid); end
    checks++; if (data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL hz_data_blocked: got %b want 0", data_sram_addr_ok); end
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL hz_inst_during_resp: got %b want 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0; bvalid = 1'b1;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL wr_bresp_ok: got %b want 1", data_sram_data_ok); end
    checks++; if (data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL hz_data_blocked_b: got %b want 0", data_sram_addr_ok); end
    tick();
    bvalid = 1'b0;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL hz_data_after_b: got ok=%b bready=%b want 1/0", data_sram_addr_ok, bready); end
    tick();
    data_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== ID_DATA || araddr !== 32'h8000_3000) begin errors++; $display("FAIL hz_ar_data: got v=%b id=%h a=%h", arvalid, arid, araddr); end
    tick();
    arready = 1'b0;
  endtask

  task automatic test_inst_pending;
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0020;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL pend_inst_blocked%0d: got %b want 0", i, inst_sram_addr_ok); end
      tick();
    end
    rvalid = 1'b1; rid = ID_INST; rdata = 32'h3333_3333;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b0 || inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL pend_rvalid_cycle: got ok=%b dok=%b want 0/1", inst_sram_addr_ok, inst_sram_data_ok); end
    tick();
    rvalid = 1'b0; arready = 1'b1;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL pend_inst_released: got %b want 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== ID_INST || araddr !== 32'hBFC0_0020) begin errors++; $display("FAIL pend_ar_inst: got v=%b id=%h a=%h", arvalid, arid, araddr); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = ID_DATA; rdata = 32'h4444_4444;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h4444_4444) begin errors++; $display("FAIL pend_data_ret: got ok=%b d=%h", data_sram_data_ok, data_sram_rdata); end
    tick();
    rid = ID_INST; rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h5555_5555) begin errors++; $display("FAIL pend_inst_ret: got ok=%b d=%h", inst_sram_data_ok, inst_sram_rdata); end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_reset_mid;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_5000;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL rm_wr_accept: got %b want 1", data_sram_addr_ok); end
    tick();
    data_sram_req = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0040;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1 || awvalid !== 1'b1) begin errors++; $display("FAIL rm_setup: got iok=%b awvalid=%b want 1/1", inst_sram_addr_ok, awvalid); end
    tick();
    inst_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rm_ar_send: got %b want 1", arvalid); end
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL rm_cleared: got ar=%b aw=%b w=%b b=%b want 0", arvalid, awvalid, wvalid, bready); end
    checks++; if (inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL rm_addr_ok: got %b%b want 00", inst_sram_addr_ok, data_sram_addr_ok); end
    tick();
    reset = 1'b0; arready = 1'b1;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h8000_6000;
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0050;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL rm_wfsm_idle: got dok=%b iok=%b want 1/0", data_sram_addr_ok, inst_sram_addr_ok); end
    tick();
    data_sram_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL rm_rdpend_clear: got %b want 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 1'b0;
    tick();
    arready = 1'b0;
  endtask

  // Model: one AR slot, one write slot, one outstanding read per ID.
  task automatic test_random;
    logic        ar_busy, wr_busy, aw_left, w_left, drain;
    logic        exp_d_rd, exp_i_rd, exp_wr;
    logic [1:0]  rd_out, rd_owed;
    logic [31:0] exp_araddr, exp_awaddr, exp_wdata;
    logic [2:0]  exp_arsize, exp_awsize;
    logic [3:0]  exp_arid, exp_wstrb;
    int          pick;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    ar_busy = 0; wr_busy = 0; aw_left = 0; w_left = 0;
    rd_out = 0; rd_owed = 0;
    exp_araddr = 0; exp_awaddr = 0; exp_wdata = 0; exp_arsize = 0; exp_awsize = 0;
    exp_arid = 0; exp_wstrb = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      drain = (cyc >= 640);
      inst_sram_req   = !drain && ($urandom_range(0, 2) == 0);
      inst_sram_addr  = $urandom & 32'hFFFF_FFFC;
      inst_sram_size  = 2'($urandom_range(0, 2));
      data_sram_req   = !drain && ($urandom_range(0, 2) == 0);
      data_sram_wr    = 1'($urandom_range(0, 1));
      data_sram_addr  = $urandom;
      data_sram_size  = 2'($urandom_range(0, 2));
      data_sram_wstrb = 4'($urandom);
      data_sram_wdata = $urandom;
      arready = drain || ($urandom_range(0, 1) == 1);
      awready = drain || ($urandom_range(0, 1) == 1);
      wready  = drain || ($urandom_range(0, 1) == 1);
      bvalid  = wr_busy && !aw_left && !w_left && (drain || ($urandom_range(0, 1) == 1));
      rvalid = 1'b0; rid = 4'($urandom_range(0, 1)); rdata = $urandom;
      if (rd_owed != 2'b00 && (drain || ($urandom_range(0, 1) == 1))) begin
        if (rd_owed == 2'b11) pick = int'($urandom_range(0, 1));
        else pick = rd_owed[1] ? 1 : 0;
        rvalid = 1'b1;
        rid = (pick == 1) ? ID_DATA : ID_INST;
      end
      @(negedge clk);
      exp_d_rd = !ar_busy && data_sram_req && !data_sram_wr && !rd_out[1] && !wr_busy;
      exp_i_rd = !ar_busy && inst_sram_req && !rd_out[0] && !exp_d_rd;
      exp_wr   = !wr_busy && data_sram_req && data_sram_wr && !rd_out[1];
      checks++; if (data_sram_addr_ok !== (exp_d_rd || exp_wr)) begin errors++; $display("FAIL rnd_data_addr_ok c%0d: got %b want %b", cyc, data_sram_addr_ok, exp_d_rd || exp_wr); end
      checks++; if (inst_sram_addr_ok !== exp_i_rd) begin errors++; $display("FAIL rnd_inst_addr_ok c%0d: got %b want %b", cyc, inst_sram_addr_ok, exp_i_rd); end
      checks++; if (arvalid !== ar_busy) begin errors++; $display("FAIL rnd_arvalid c%0d: got %b want %b", cyc, arvalid, ar_busy); end
      if (ar_busy) begin
        checks++; if (araddr !== exp_araddr || arid !== exp_arid || arsize !== exp_arsize) begin errors++; $display("FAIL rnd_ar_fields c%0d: got %h/%h/%h want %h/%h/%h", cyc, araddr, arid, arsize, exp_araddr, exp_arid, exp_arsize); end
      end
      checks++; if (awvalid !== aw_left || wvalid !== w_left) begin errors++; $display("FAIL rnd_aw_w_valid c%0d: got %b%b want %b%b", cyc, awvalid, wvalid, aw_left, w_left); end
      checks++; if (bready !== (wr_busy && !aw_left && !w_left)) begin errors++; $display("FAIL rnd_bready c%0d: got %b", cyc, bready); end
      if (aw_left) begin
        checks++; if (awaddr !== exp_awaddr || awsize !== exp_awsize) begin errors++; $display("FAIL rnd_aw_fields c%0d: got %h/%h want %h/%h", cyc, awaddr, awsize, exp_awaddr, exp_awsize); end
      end
      if (w_left) begin
        checks++; if (wdata !== exp_wdata || wstrb !== exp_wstrb) begin errors++; $display("FAIL rnd_w_fields c%0d: got %h/%h want %h/%h", cyc, wdata, wstrb, exp_wdata, exp_wstrb); end
      end
      checks++; if (inst_sram_data_ok !== (rvalid && rid == ID_INST)) begin errors++; $display("FAIL rnd_inst_data_ok c%0d: got %b", cyc, inst_sram_data_ok); end
      checks++; if (data_sram_data_ok !== ((rvalid && rid == ID_DATA) || bvalid)) begin errors++; $display("FAIL rnd_data_data_ok c%0d: got %b", cyc, data_sram_data_ok); end
      if (rvalid) begin
        checks++; if ((rid == ID_INST ? inst_sram_rdata : data_sram_rdata) !== rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h", cyc, inst_sram_rdata, data_sram_rdata, rdata); end
      end
      // Advance the model to the next cycle.
      if (ar_busy && arready) begin ar_busy = 1'b0; rd_owed[exp_arid[0]] = 1'b1; end
      if (rvalid) begin rd_out[rid[0]] = 1'b0; rd_owed[rid[0]] = 1'b0; end
      if (exp_d_rd || exp_i_rd) begin
        ar_busy    = 1'b1;
        exp_arid   = exp_d_rd ? ID_DATA : ID_INST;
        exp_araddr = exp_d_rd ? data_sram_addr : inst_sram_addr;
        exp_arsize = {1'b0, exp_d_rd ? data_sram_size : inst_sram_size};
        rd_out[exp_arid[0]] = 1'b1;
      end
      if (aw_left && awready) aw_left = 1'b0;
      if (w_left && wready) w_left = 1'b0;
      if (bvalid) wr_busy = 1'b0;
      if (exp_wr) begin
        wr_busy = 1'b1; aw_left = 1'b1; w_left = 1'b1;
        exp_awaddr = data_sram_addr; exp_awsize = {1'b0, data_sram_size};
        exp_wdata = data_sram_wdata; exp_wstrb = data_sram_wstrb;
      end
      tick();
    end
    checks++; if (rd_out != 2'b00 || wr_busy) begin errors++; $display("FAIL rnd_drain: reads=%b write=%b still open", rd_out, wr_busy); end
    inst_sram_req = 1'b0; data_sram_req = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_size = 0; inst_sram_addr = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    test_reset();
    test_arbitration();
    test_out_of_order();
    test_write_hazard();
    test_inst_pending();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_axi_arbiter.md
Name: sram_axi_arbiter

Overview:
Shares the core's single AXI master port between the instruction sram-like requester (fetch side) and the data sram-like requester (memory stage). It accepts requests with an addr_ok/data_ok handshake and converts them into single-beat AXI read and write transactions. It tracks outstanding reads by ARID, so fetch and data reads may both be in flight. It enforces read/write ordering on the data side.

Parameters:
ID_INST, 4'd0, ARID/RID tag for instruction reads
ID_DATA, 4'd1, ARID/RID/AWID tag for data accesses

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_sram_req  in  1  fetch read request
inst_sram_size  in  2  log2 bytes (0/1/2)
inst_sram_addr  in  32  fetch address
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  fetch data valid this cycle
inst_sram_rdata  out  32  fetch data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  log2 bytes
data_sram_wstrb  in  4  byte enables
data_sram_addr  in  32  data address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  request accepted
data_sram_data_ok  out  1  read data valid / write complete
data_sram_rdata  out  32  read data
arid  out  4 / araddr  out  32 / arsize  out  3 / arvalid  out  1 / arready  in  1
rid  in  4 / rdata  in  32 / rvalid  in  1 / rready  out  1
awaddr  out  32 / awsize  out  3 / awvalid  out  1 / awready  in  1
wdata  out  32 / wstrb  out  4 / wvalid  out  1 / wready  in  1
bvalid  in  1 / bready  out  1
(awid=ID_DATA, len=0, burst=INCR, wlast=1 are tied off at the top level.)

Behaviour:
- Reset: all valid/ready outputs are 0, except rready, which is constant 1. Address, data and strobe registers are 0. rd_pend[1:0] is 0. Both FSMs are IDLE.
- Read FSM states: AR_IDLE and AR_SEND.
  - In AR_IDLE, select data first, then inst:
    - Data read is eligible when data_sram_req && !data_sram_wr && !rd_pend[1] && write FSM is W_IDLE.
    - Inst read is eligible when inst_sram_req && !rd_pend[0].
  - The selected requester gets addr_ok=1 combinationally in the same cycle.
  - Next cycle: arvalid=1 with registered araddr, arsize={1'b0,size} and arid. The matching rd_pend bit is set. State goes to AR_SEND.
  - AR_SEND holds until arvalid && arready, then returns to AR_IDLE. No new read is accepted in AR_SEND, so at most one read is accepted every 2 cycles.
- Read return: rready=1 always.
  - rvalid with rid==ID_INST gives inst_sram_data_ok=1, inst_sram_rdata=rdata, and clears rd_pend[0].
  - rvalid with rid==ID_DATA gives data_sram_data_ok=1, data_sram_rdata=rdata, and clears rd_pend[1].
  - Out-of-order return between the two IDs is legal.
  - If a set and a clear of the same rd_pend bit occur in the same cycle, the set wins.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE accepts a data write when data_sram_req && data_sram_wr && !rd_pend[1] && read FSM is not accepting a data read that cycle. On accept, data_sram_addr_ok=1.
  - W_SEND: awvalid and wvalid are asserted together. Each drops independently after its own handshake. Go to W_RESP once both handshakes are done, including the case where both complete in the same cycle.
  - W_RESP: bready=1. On bvalid, data_sram_data_ok=1 and the FSM returns to W_IDLE.
- data_sram_addr_ok is the OR of the read and write accepts. The two are mutually exclusive by construction.
- Ordering hazards:
  - Data reads are blocked while a write is outstanding.
  - Writes are blocked while a data read is outstanding.
  - As a result, a read data_ok and a write data_ok never occur in the same cycle on the data port.
- Inst reads may proceed while a write is in flight.
- Reset mid-operation clears all state. The AXI slave is reset by the same signal, so no in-flight responses are expected after reset.
- An rvalid whose rid matches no pending bit is an error. It must be flagged by a bench assertion; the RTL ignores it.

Decomposition:
- Shared package:
  - ID_INST and ID_DATA constants.
  - AR_* and W_* state encodings.
  - AXI fixed-field constants (LEN0, BURST_INCR).
- One sub-module: axi_wr_channel, containing the W_IDLE/W_SEND/W_RESP FSM and the AW/W/B registers. The parent keeps read arbitration, rd_pend and data_ok muxing.

Test Plan:
- Both requesters assert req together (inst addr 0xBFC00000, data read 0x80001000); arready=1.
  - Required: data gets addr_ok in cycle 0, arid=1.
  - Inst gets addr_ok in cycle 2, arid=0.
- Reads out of order: rid=0 returns 0x11111111 before rid=1 returns 0x22222222.
  - Required: inst_sram_data_ok with 0x11111111 first, then data_sram_data_ok with 0x22222222.
- Data write to 0x80002000, wdata 0xDEADBEEF, wstrb 4'b0011; awready delayed 3 cycles, wready immediate.
  - Required: awvalid held for 3 cycles, wvalid dropped after 1 cycle.
  - bvalid produces data_sram_data_ok in the same cycle.
- Data read requested while a write is in W_RESP.
  - Required: data_sram_addr_ok=0 until the cycle after bvalid.
  - Inst read is still accepted during W_RESP.
- Second inst request while rd_pend[0]=1.
  - Required: inst_sram_addr_ok stays 0 until the rvalid/rid=0 cycle completes.
- reset asserted in AR_SEND with arvalid=1.
  - Required: next cycle arvalid=0, rd_pend=0, both FSMs IDLE, all addr_ok=0.
